// File: rtl/mem_bist_pkg.sv
// Shared types and default sizing for the memory BIST master.
package mem_bist_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        FIN
    } state_t;

endpackage

// File: rtl/mem_bist_wdog.sv
// Ready-wait watchdog: counts request cycles and flags when the limit is reached.
module mem_bist_wdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic res,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(LIMIT));

    // Count waiting cycles; saturate at the limit so expired stays asserted.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes an incrementing pattern over a wrapping address
// window, reads it back, and reports mismatches or a ready timeout.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [WIDTH-1:0]      seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    // Word counts beyond the memory size collapse to one full pass.
    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] l);
        return (l > LW'(DEPTH)) ? LW'(DEPTH) : l;
    endfunction

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [LW-1:0]         len_r;
    logic [LW-1:0]         idx;
    logic [WIDTH-1:0]      seed_r;
    logic                  pass_r;
    logic                  timeout_r;
    logic [LW-1:0]         err_r;
    logic [ADDR_WIDTH-1:0] first_r;
    logic                  in_req;
    logic                  expired;
    logic                  last;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [WIDTH-1:0]      pattern;

    assign cur_addr       = base_r + idx[ADDR_WIDTH-1:0];
    assign pattern        = seed_r + WIDTH'(idx);
    assign in_req         = (state == WR_REQ) || (state == RD_REQ);
    assign last           = ((idx + LW'(1)) == len_r);
    assign timeout        = timeout_r;
    assign err_count      = err_r;
    assign first_err_addr = first_r;

    // The watchdog restarts whenever a request phase is (re)entered.
    mem_bist_wdog #(.LIMIT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .res     (res),
        .clear   (!in_req),
        .enable  (in_req),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and request/status outputs.
    always_comb begin
        next_state = state;
        valid      = 1'b0;
        wr_rd      = 1'b0;
        addr       = '0;
        wdata      = '0;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = pass_r;
        case (state)
            IDLE: begin
                if (start) next_state = (sat_len(len) == '0) ? FIN : WR_REQ;
            end
            WR_REQ: begin
                busy  = 1'b1;
                wr_rd = 1'b1;
                addr  = cur_addr;
                wdata = pattern;
                valid = !expired;
                if (expired)    next_state = FIN;
                else if (ready) next_state = WR_GAP;
            end
            WR_GAP: begin
                busy       = 1'b1;
                addr       = cur_addr;
                next_state = last ? RD_REQ : WR_REQ;
            end
            RD_REQ: begin
                busy  = 1'b1;
                addr  = cur_addr;
                valid = !expired;
                if (expired)    next_state = FIN;
                else if (ready) next_state = RD_GAP;
            end
            RD_GAP: begin
                busy       = 1'b1;
                addr       = cur_addr;
                next_state = last ? FIN : RD_REQ;
            end
            FIN: begin
                done       = 1'b1;
                pass       = (err_r == '0) && !timeout_r;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result registers: cleared on an accepted start, held until the next one.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_r     <= '0;
            first_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pass_r    <= 1'b0;
                        timeout_r <= 1'b0;
                        err_r     <= '0;
                        first_r   <= '0;
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (expired) begin
                        timeout_r <= 1'b1;
                    end else if (ready && (state == RD_REQ) && (rdata != pattern)) begin
                        err_r <= err_r + LW'(1);
                        if (err_r == '0) first_r <= cur_addr;
                    end
                end
                FIN:     pass_r <= (err_r == '0) && !timeout_r;
                default: ;
            endcase
        end
    end

    // Test window and word index; only meaningful while a test is running.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) begin
            base_r <= base_addr;
            len_r  <= sat_len(len);
            seed_r <= seed;
            idx    <= '0;
        end else if ((state == WR_GAP) || (state == RD_GAP)) begin
            idx <= last ? '0 : idx + LW'(1);
        end
    end

endmodule
